// File: rtl/pong_pkg.sv
// pong_pkg: playfield limits, ball FSM states and coordinate/direction types shared by the pong blocks.
package pong_pkg;
  localparam int X_MAX = 799;
  localparam int Y_MAX = 599;
  localparam int WIN_SCORE = 9;
  typedef enum logic [1:0] {SERVE, PLAY, SCORED, OVER} ball_state_t;
  typedef logic [9:0] coord_t;
  typedef logic signed [1:0] dir_t;
  localparam dir_t DIR_POS = 2'sb01;
  localparam dir_t DIR_NEG = 2'sb11;
  function automatic coord_t step_coord(input coord_t c, input dir_t d);
    return c + {{8{d[1]}}, d};
  endfunction
endpackage

// File: rtl/ball_controller_if.sv
// ball_controller_if: run control and paddle positions in, ball position, scores and event pulses out.
interface ball_controller_if;
  import pong_pkg::*;
  logic game_on;
  logic signed [31:0] left_pos;
  logic signed [31:0] right_pos;
  coord_t ball_x;
  coord_t ball_y;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic hit_left;
  logic hit_right;
  logic point_left;
  logic point_right;
  logic game_over;
  modport master (
    output game_on, left_pos, right_pos,
    input ball_x, ball_y, score_left, score_right, hit_left, hit_right, point_left, point_right, game_over
  );
  modport slave (
    input game_on, left_pos, right_pos,
    output ball_x, ball_y, score_left, score_right, hit_left, hit_right, point_left, point_right, game_over
  );
endinterface

// File: rtl/step_timer.sv
// step_timer: enable-gated down-counter; step_o strobes once every period_i enabled clocks.
module step_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] period_i,
  output logic       step_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    step_o = en_i && cnt_q == '0;
    cnt_d = (clr_i || step_o) ? period_i - 8'd1 : en_i ? cnt_q - 8'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ball_controller.sv
// ball_controller: ball motion, wall/paddle bounces, scoring and serve/pause sequencing.
// Defining BALL_SPEEDUP_EN shortens the step period on every paddle hit until the next serve.
module ball_controller
  import pong_pkg::*;
#(
  parameter int LEFT_X = 16,
  parameter int RIGHT_X = 783,
  parameter int PADDLE_HALF = 40,
  parameter int TICKS_PER_STEP = 4,
  parameter int SERVE_CYCLES = 64,
  parameter int PAUSE_CYCLES = 128
) (
  input logic clk,
  input logic reset,
  ball_controller_if.slave bus
);
  ball_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  coord_t x_q, x_d, y_q, y_d;
  dir_t dx_q, dx_d, dy_q, dy_d, ndy;
  logic [3:0] sl_q, sl_d, sr_q, sr_d;
  logic hl_q, hl_d, hr_q, hr_d, pl_q, pl_d, pr_q, pr_d, go_q, go_d;
  logic step, bounce_y, hit_l, hit_r, miss_l, miss_r;
  logic signed [31:0] dist_l, dist_r;
  logic [7:0] period_d;
  step_timer u_timer (
    .clk(clk),
    .reset(reset),
    .en_i(bus.game_on && state_q == PLAY),
    .clr_i(bus.game_on && state_q != PLAY),
    .period_i(period_d),
    .step_o(step)
  );
`ifdef BALL_SPEEDUP_EN
  logic [7:0] period_q;
  always_comb
    period_d = (state_d == SERVE && state_q != SERVE) ? 8'(TICKS_PER_STEP) :
               ((hl_d || hr_d) && period_q > 8'd2) ? period_q - 8'd1 : period_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) period_q <= 8'(TICKS_PER_STEP);
    else period_q <= period_d;
`else
  assign period_d = 8'(TICKS_PER_STEP);
`endif
  always_comb begin
    bounce_y = (dy_q == DIR_NEG && y_q == '0) || (dy_q == DIR_POS && y_q == coord_t'(Y_MAX));
    ndy = bounce_y ? -dy_q : dy_q;
    dist_l = $signed({22'd0, y_q}) - bus.left_pos;
    dist_r = $signed({22'd0, y_q}) - bus.right_pos;
    hit_l = dx_q == DIR_NEG && x_q == coord_t'(LEFT_X + 1) && dist_l <= PADDLE_HALF && dist_l >= -PADDLE_HALF;
    hit_r = dx_q == DIR_POS && x_q == coord_t'(RIGHT_X - 1) && dist_r <= PADDLE_HALF && dist_r >= -PADDLE_HALF;
    miss_l = dx_q == DIR_NEG && x_q == '0;
    miss_r = dx_q == DIR_POS && x_q == coord_t'(X_MAX);
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    sl_d = sl_q;
    sr_d = sr_q;
    go_d = go_q;
    hl_d = 1'b0;
    hr_d = 1'b0;
    pl_d = 1'b0;
    pr_d = 1'b0;
    if (bus.game_on) begin
      case (state_q)
        SERVE: begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'(SERVE_CYCLES - 1)) begin
            state_d = PLAY;
            cnt_d = '0;
          end
        end
        PLAY: if (step) begin
          y_d = step_coord(y_q, ndy);
          dy_d = ndy;
          if (hit_l) begin
            dx_d = DIR_POS;
            x_d = coord_t'(LEFT_X + 2);
            hl_d = 1'b1;
          end else if (hit_r) begin
            dx_d = DIR_NEG;
            x_d = coord_t'(RIGHT_X - 2);
            hr_d = 1'b1;
          end else if (miss_l) begin
            sr_d = (sr_q == 4'(WIN_SCORE)) ? sr_q : sr_q + 4'd1;
            go_d = go_q || sr_d == 4'(WIN_SCORE);
            pr_d = 1'b1;
            state_d = SCORED;
          end else if (miss_r) begin
            sl_d = (sl_q == 4'(WIN_SCORE)) ? sl_q : sl_q + 4'd1;
            go_d = go_q || sl_d == 4'(WIN_SCORE);
            pl_d = 1'b1;
            state_d = SCORED;
          end else
            x_d = step_coord(x_q, dx_q);
        end
        SCORED: begin
          cnt_d = cnt_q + 16'd1;
          // dx is left untouched: it already points at the player who just lost the point
          if (cnt_q == 16'(PAUSE_CYCLES - 1)) begin
            cnt_d = '0;
            state_d = go_q ? OVER : SERVE;
            if (!go_q) begin
              x_d = coord_t'(X_MAX / 2);
              y_d = coord_t'(Y_MAX / 2);
              dy_d = DIR_POS;
            end
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= SERVE;
      cnt_q <= '0;
      x_q <= coord_t'(X_MAX / 2);
      y_q <= coord_t'(Y_MAX / 2);
      dx_q <= DIR_POS;
      dy_q <= DIR_POS;
      sl_q <= '0;
      sr_q <= '0;
      go_q <= 1'b0;
      hl_q <= 1'b0;
      hr_q <= 1'b0;
      pl_q <= 1'b0;
      pr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      sl_q <= sl_d;
      sr_q <= sr_d;
      go_q <= go_d;
      hl_q <= hl_d;
      hr_q <= hr_d;
      pl_q <= pl_d;
      pr_q <= pr_d;
    end
  assign bus.ball_x = x_q;
  assign bus.ball_y = y_q;
  assign bus.score_left = sl_q;
  assign bus.score_right = sr_q;
  assign bus.hit_left = hl_q;
  assign bus.hit_right = hr_q;
  assign bus.point_left = pl_q;
  assign bus.point_right = pr_q;
  assign bus.game_over = go_q;
endmodule

// File: tb/tb_ball_controller.sv
// tb_ball_controller: directed rally with hand-derived ball trajectory, freeze, scoring to game over and async resets.
module tb_ball_controller;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int en_edges = 0;
  localparam int E = 64 + 4 * 2696;
  ball_controller_if bus();
  ball_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask
  // advance enabled clocks until the count since reset release reaches target; sample 1ns after the edge
  task automatic adv(input int target);
    while (en_edges < target) begin
      @(posedge clk);
      en_edges++;
    end
    #1;
  endtask
  initial begin
    bus.game_on = 1'b0;
    bus.left_pos = 289;
    bus.right_pos = 476;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", bus.ball_x, 399);
    chk("rst_y", bus.ball_y, 299);
    chk("rst_scores", {bus.score_left, bus.score_right}, 0);
    chk("rst_pulses", {bus.hit_left, bus.hit_right, bus.point_left, bus.point_right, bus.game_over}, 0);
    reset = 1'b1;
    bus.game_on = 1'b1;
    adv(64);
    chk("serve_x", bus.ball_x, 399);
    chk("serve_y", bus.ball_y, 299);
    adv(67);
    chk("pre_step1_x", bus.ball_x, 399);
    adv(68);
    chk("step1_x", bus.ball_x, 400);
    chk("step1_y", bus.ball_y, 300);
    adv(106);
    bus.game_on = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("freeze_x", bus.ball_x, 409);
    chk("freeze_y", bus.ball_y, 309);
    chk("freeze_pulses", {bus.hit_left, bus.hit_right, bus.point_left, bus.point_right}, 0);
    bus.game_on = 1'b1;
    adv(107);
    chk("resume_hold_x", bus.ball_x, 409);
    adv(108);
    chk("resume_step_x", bus.ball_x, 410);
    chk("resume_step_y", bus.ball_y, 310);
    adv(64 + 4 * 300);
    chk("bottom_x", bus.ball_x, 699);
    chk("bottom_y", bus.ball_y, 599);
    adv(64 + 4 * 301);
    chk("bounce_x", bus.ball_x, 700);
    chk("bounce_y", bus.ball_y, 598);
    adv(64 + 4 * 383);
    chk("rface_x", bus.ball_x, 782);
    chk("rface_y", bus.ball_y, 516);
    adv(64 + 4 * 384);
    chk("rhit_x", bus.ball_x, 781);
    chk("rhit_y", bus.ball_y, 515);
    chk("rhit_pulse", bus.hit_right, 1);
    adv(64 + 4 * 384 + 1);
    chk("rhit_pulse_end", bus.hit_right, 0);
    adv(64 + 4 * 1148);
    chk("lface_x", bus.ball_x, 17);
    chk("lface_y", bus.ball_y, 249);
    adv(64 + 4 * 1149);
    chk("lhit_x", bus.ball_x, 18);
    chk("lhit_y", bus.ball_y, 250);
    chk("lhit_pulse", bus.hit_left, 1);
    adv(64 + 4 * 1149 + 1);
    chk("lhit_pulse_end", bus.hit_left, 0);
    bus.right_pos = 184;
    adv(64 + 4 * 1914);
    chk("rhit2_x", bus.ball_x, 781);
    chk("rhit2_y", bus.ball_y, 183);
    chk("rhit2_pulse", bus.hit_right, 1);
    bus.left_pos = 540;
    adv(64 + 4 * 2679);
    chk("lmiss_x", bus.ball_x, 16);
    chk("lmiss_y", bus.ball_y, 582);
    chk("lmiss_nohit", bus.hit_left, 0);
    bus.left_pos = -1000;
    adv(E);
    chk("pt1_pulse", bus.point_right, 1);
    chk("pt1_score_r", bus.score_right, 1);
    chk("pt1_score_l", bus.score_left, 0);
    chk("pt1_over", bus.game_over, 0);
    adv(E + 1);
    chk("pt1_pulse_end", bus.point_right, 0);
    adv(E + 127);
    chk("pause_frozen_x", bus.ball_x, 0);
    adv(E + 128);
    chk("recentre_x", bus.ball_x, 399);
    chk("recentre_y", bus.ball_y, 299);
    adv(E + 196);
    chk("serve2_x", bus.ball_x, 398);
    chk("serve2_y", bus.ball_y, 300);
    for (int k = 2; k <= 9; k++) begin
      adv(E + (k - 1) * 1792);
      chk($sformatf("pt%0d_pulse", k), bus.point_right, 1);
      chk($sformatf("pt%0d_score_r", k), bus.score_right, k);
      chk($sformatf("pt%0d_over", k), bus.game_over, (k == 9) ? 1 : 0);
    end
    adv(E + 8 * 1792 + 60);
    chk("pause9_x", bus.ball_x, 0);
    chk("pause9_over", bus.game_over, 1);
    adv(E + 8 * 1792 + 500);
    chk("over_x", bus.ball_x, 0);
    chk("over_score_r", bus.score_right, 9);
    chk("over_sticky", bus.game_over, 1);
    chk("over_nopulse", bus.point_right, 0);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_score_r", bus.score_right, 0);
    chk("arst_over", bus.game_over, 0);
    chk("arst_x", bus.ball_x, 399);
    chk("arst_y", bus.ball_y, 299);
    bus.right_pos = -1000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    en_edges = 0;
    adv(64 + 4 * 401);
    chk("ptl_pulse", bus.point_left, 1);
    chk("ptl_score_l", bus.score_left, 1);
    chk("ptl_x", bus.ball_x, 799);
    adv(64 + 4 * 401 + 60);
    #3;
    reset = 1'b0;
    #1;
    chk("midpause_score_l", bus.score_left, 0);
    chk("midpause_x", bus.ball_x, 399);
    chk("midpause_y", bus.ball_y, 299);
    chk("midpause_pulse", bus.point_left, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_controller.md
Name: ball_controller

Overview:
- Ball/game engine; sits directly downstream of both paddle trackers and consumes their centre-pixel positions.
- Moves the ball one pixel per axis per step, bounces it off the top/bottom walls and the paddles, detects missed balls, keeps score and sequences serve/pause.
- Feeds the pixel renderer (ball_x, ball_y) and the score display.

Parameters:
- X_MAX, 799, rightmost ball x pixel; the playfield is 0..X_MAX.
- Y_MAX, 599, bottom ball y pixel; the playfield is 0..Y_MAX. Matches the paddle Y range.
- LEFT_X, 16, x column of the left paddle face.
- RIGHT_X, 783, x column of the right paddle face.
- PADDLE_HALF, 40, hit window half-height in pixels.
- TICKS_PER_STEP, 4, clocks per ball step (minimum 2).
- SERVE_CYCLES, 64, clocks the ball is held at centre before launch.
- PAUSE_CYCLES, 128, clocks held in SCORED after a point.
- WIN_SCORE, 9, score that ends the game.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- game_on, input, 1, run enable. When low, all state freezes.
- left_pos, input, 32 signed, left paddle centre y.
- right_pos, input, 32 signed, right paddle centre y.
- ball_x, output, 10, ball column.
- ball_y, output, 10, ball row.
- score_left, output, 4, left player points.
- score_right, output, 4, right player points.
- hit_left, output, 1, one-clock pulse on a left paddle bounce.
- hit_right, output, 1, one-clock pulse on a right paddle bounce.
- point_left, output, 1, one-clock pulse when the left player scores.
- point_right, output, 1, one-clock pulse when the right player scores.
- game_over, output, 1, sticky high once either score equals WIN_SCORE.

Behaviour:
- Reset is asynchronous, active-low, applies immediately (including mid-operation) and sets:
  - state=SERVE, counters=0, ball_x=X_MAX/2 (399), ball_y=Y_MAX/2 (299), dx=+1, dy=+1;
  - scores=0, all pulses=0, game_over=0.
- States:
  - SERVE: ball held at centre; after SERVE_CYCLES enabled clocks -> PLAY.
  - PLAY: step counter counts enabled clocks; the step fires when the count reaches TICKS_PER_STEP-1, then the counter returns to 0.
  - SCORED: ball frozen; after PAUSE_CYCLES -> SERVE, or -> OVER if game_over.
  - OVER: terminal; only reset leaves it.
- Step evaluation, all computed from pre-step registered values, updated together on the step clock:
  - Y: if dy=-1 and y=0, or dy=+1 and y=Y_MAX, negate dy and move y by the new dy; otherwise y+=dy.
  - X, left: if dx=-1 and x=LEFT_X+1 and |y-left_pos|<=PADDLE_HALF (signed 32-bit compare, y zero-extended), set dx=+1, x=LEFT_X+2, and pulse hit_left.
  - X, right: mirrored at RIGHT_X-1 using right_pos; pulse hit_right.
  - X, miss: if dx=-1 and x=0, right player scores; if dx=+1 and x=X_MAX, left player scores. Otherwise x+=dx.
  - Simultaneous wall and paddle bounce in one step: both are applied.
- On a point:
  - pulse the corresponding point_* in the same clock and increment that score;
  - set game_over if the new score equals WIN_SCORE;
  - go to SCORED.
- On SCORED -> SERVE: recentre the ball; dx points toward the player who lost the point; dy=+1.
- Scores never exceed WIN_SCORE; no wrap.
- game_on low: every counter, the state, the ball and dx/dy hold; no pulses are emitted. Resuming continues exactly where it stopped.
- Pulses are registered; each is high for exactly one clock.
- Paddle positions outside 0..Y_MAX are still compared arithmetically, with no clamping.

Optional Feature:
- BALL_SPEEDUP_EN defined:
  - each paddle hit decrements the active step period by 1, floored at 2;
  - the period restores to TICKS_PER_STEP on every entry to SERVE.
- Not defined: the step period stays at TICKS_PER_STEP and no decrement logic exists.

Decomposition:
- pong_pkg holds:
  - X_MAX, Y_MAX and WIN_SCORE constants;
  - typedef enum ball_state_t {SERVE, PLAY, SCORED, OVER};
  - typedef logic [9:0] coord_t;
  - typedef logic signed [1:0] dir_t.
  - The paddle block also takes Y_MAX from pong_pkg.
- One sub-module: step_timer, an enable-gated down-counter with a programmable period that emits a one-clock step strobe.

Test Plan:
- Reset, then game_on=1 for 64 clocks -> ball stays at (399,299); PLAY is entered; after 4 more clocks ball=(400,300).
- Ball at y=599, dy=+1, step -> y=598, dy=-1, and the x step is applied normally.
- left_pos=300, ball (17,330), dx=-1, step -> x=18, dx=+1, hit_left pulses once. Repeat with left_pos=250 -> no hit; ball reaches x=0; next step gives point_right=1, score_right=1, state SCORED.
- Drop game_on for 50 clocks mid-PLAY -> ball_x, ball_y, counters and state unchanged; after raising game_on, the next step lands exactly 4 enabled clocks after the last one.
- Run the right player to 9 points -> game_over=1 on the 9th point_right; stays in OVER; score_right stays 9; asserting reset mid-pause clears everything at once.
- With BALL_SPEEDUP_EN: 3 hits -> step period 4->3->2->2; after the next serve the period is 4 again.
